// File: rtl/gcd_engine.sv
// Subtractive-Euclid GCD engine with valid/ready operand and result handshakes.
// Define GCD_ITER_COUNT_EN to add the iteration counter and its iter_o port.
module gcd_engine #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             enable_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] gcd_o,
   output logic             flag_init_o,
   output logic             flag_compute_o,
   output logic             flag_finish_o
`ifdef GCD_ITER_COUNT_EN
   ,
   output logic [CNT_W-1:0] iter_o
`endif
);

   localparam logic [1:0] S_INIT    = 2'd0;
   localparam logic [1:0] S_COMPUTE = 2'd1;
   localparam logic [1:0] S_FINISH  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] gcd_q, gcd_d;
   logic             accept;
   logic             release_res;
   logic             term;

   assign in_ready_o  = enable_i & (state_q == S_INIT);
   assign accept      = in_valid_i & in_ready_o;
   assign out_valid_o = (state_q == S_FINISH);
   assign release_res = out_valid_o & out_ready_i & enable_i;
   assign term        = (a_q == '0) | (b_q == '0) | (a_q == b_q);
   assign gcd_o       = gcd_q;

   // Any encoding other than COMPUTE/FINISH reads as INIT so one flag is always high.
   assign flag_compute_o = (state_q == S_COMPUTE);
   assign flag_finish_o  = (state_q == S_FINISH);
   assign flag_init_o    = ~(flag_compute_o | flag_finish_o);

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      gcd_d   = gcd_q;
      case (state_q)
         S_INIT: begin
            if (accept) begin
               a_d     = a_i;
               b_d     = b_i;
               state_d = S_COMPUTE;
            end
         end
         S_COMPUTE: begin
            if (term) begin
               gcd_d   = (a_q == '0) ? b_q : a_q;
               state_d = S_FINISH;
            end else if (a_q > b_q) begin
               a_d = a_q - b_q;
            end else begin
               b_d = b_q - a_q;
            end
         end
         S_FINISH: begin
            if (release_res) begin
               state_d = S_INIT;
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= S_INIT;
         a_q     <= '0;
         b_q     <= '0;
         gcd_q   <= '0;
      end else if (enable_i) begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         gcd_q   <= gcd_d;
      end
   end

`ifdef GCD_ITER_COUNT_EN
   logic [CNT_W-1:0] iter_q, iter_d;

   always_comb begin
      iter_d = iter_q;
      if (accept) begin
         iter_d = '0;
      end else if (state_q == S_COMPUTE && !(&iter_q)) begin
         iter_d = iter_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         iter_q <= '0;
      end else if (enable_i) begin
         iter_q <= iter_d;
      end
   end

   assign iter_o = iter_q;
`endif

endmodule

// File: tb/tb_gcd_engine.sv
// Self-checking bench for gcd_engine (WIDTH=8): directed table, corner sequences, random jobs.
// Checks iter_o as well when GCD_ITER_COUNT_EN is defined.
module tb_gcd_engine;

   localparam int unsigned W     = 8;
   localparam int unsigned CW    = 16;
   localparam int          STALL = 4;

   logic          clk;
   logic          reset;
   logic          enable;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a_in;
   logic [W-1:0]  b_in;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  gcd;
   logic          f_init;
   logic          f_comp;
   logic          f_fin;
`ifdef GCD_ITER_COUNT_EN
   logic [CW-1:0] iter;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   gcd_engine #(
      .WIDTH(W),
      .CNT_W(CW)
   ) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .enable_i      (enable),
      .in_valid_i    (in_valid),
      .in_ready_o    (in_ready),
      .a_i           (a_in),
      .b_i           (b_in),
      .out_valid_o   (out_valid),
      .out_ready_i   (out_ready),
      .gcd_o         (gcd),
      .flag_init_o   (f_init),
      .flag_compute_o(f_comp),
      .flag_finish_o (f_fin)
`ifdef GCD_ITER_COUNT_EN
      ,
      .iter_o        (iter)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference model: modulo Euclid; compute cycles = sum of quotients (one subtraction
   // per quotient unit, the last unit being the terminating equal step), or 1 on a zero.
   function automatic int ref_gcd(input int a, input int b);
      int x = a;
      int y = b;
      int t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   function automatic int ref_cycles(input int a, input int b);
      int x = a;
      int y = b;
      int s = 0;
      int t;
      if (a == 0 || b == 0) return 1;
      while (y != 0) begin
         s += x / y;
         t = x % y;
         x = y;
         y = t;
      end
      return s;
   endfunction

   // Entered and left at a negedge. stall_at<0 means no enable stall.
   task automatic run_job(input string name, input int a, input int b, input int exp_g,
                          input int exp_n, input int stall_at, input int bp_cycles);
      int lat;
      int exp_lat;
      int limit;
      exp_lat   = exp_n + ((stall_at >= 0) ? STALL : 0);
      limit     = exp_lat + 20;
      out_ready = (bp_cycles == 0);
      in_valid  = 1'b1;
      a_in      = W'(a);
      b_in      = W'(b);
      check({name, " in_ready before accept"}, in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      lat = 0;
      while (!out_valid && lat < limit) begin
         if (lat == stall_at) enable = 1'b0;
         if (stall_at >= 0 && lat == stall_at + STALL) enable = 1'b1;
         // Noise on the operand side must be ignored outside INIT.
         in_valid = 1'($urandom_range(0, 1));
         a_in     = W'($urandom);
         b_in     = W'($urandom);
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (!enable) begin
            check({name, " stalled flag_compute"}, f_comp, 1);
            check({name, " stalled in_ready"}, in_ready, 0);
         end
      end
      enable   = 1'b1;
      in_valid = 1'b0;
      check({name, " out_valid"}, out_valid, 1);
      check({name, " latency"}, lat, exp_lat);
      check({name, " gcd"}, gcd, exp_g);
      check({name, " flag_finish"}, f_fin, 1);
`ifdef GCD_ITER_COUNT_EN
      check({name, " iter"}, iter, exp_n);
`endif
      for (int i = 0; i < bp_cycles; i++) begin
         @(negedge clk);
         check({name, " held out_valid"}, out_valid, 1);
         check({name, " held gcd"}, gcd, exp_g);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check({name, " out_valid after release"}, out_valid, 0);
      check({name, " in_ready after release"}, in_ready, 1);
`ifdef GCD_ITER_COUNT_EN
      check({name, " iter held in INIT"}, iter, exp_n);
`endif
   endtask

   typedef struct {
      int a;
      int b;
      int g;
      int n;
   } vec_t;

   vec_t vecs[9];

   initial begin
      vecs[0] = '{a: 12,  b: 8,   g: 4,   n: 3};
      vecs[1] = '{a: 0,   b: 0,   g: 0,   n: 1};
      vecs[2] = '{a: 0,   b: 9,   g: 9,   n: 1};
      vecs[3] = '{a: 9,   b: 0,   g: 9,   n: 1};
      vecs[4] = '{a: 7,   b: 7,   g: 7,   n: 1};
      vecs[5] = '{a: 1,   b: 255, g: 1,   n: 255};
      vecs[6] = '{a: 48,  b: 18,  g: 6,   n: 5};
      vecs[7] = '{a: 255, b: 255, g: 255, n: 1};
      vecs[8] = '{a: 128, b: 64,  g: 64,  n: 2};

      reset     = 1'b1;
      enable    = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a_in      = '0;
      b_in      = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("reset flag_init", f_init, 1);
      check("reset flag_compute", f_comp, 0);
      check("reset flag_finish", f_fin, 0);
      check("reset in_ready", in_ready, 1);
      check("reset out_valid", out_valid, 0);
      check("reset gcd", gcd, 0);
`ifdef GCD_ITER_COUNT_EN
      check("reset iter", iter, 0);
`endif
      enable = 1'b0;
      #1;
      check("disabled in_ready", in_ready, 0);
      enable = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         run_job($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].g, vecs[i].n, -1, 0);
      end

      // Long job with 5 cycles of result backpressure.
      run_job("bp255_1", 255, 1, 1, 255, -1, 5);

      // Enable stall mid-compute: result 4 cycles late.
      run_job("stall48_18", 48, 18, 6, 5, 2, 0);

      // Reset mid-compute, then a fresh job.
      in_valid = 1'b1;
      a_in     = W'(100);
      b_in     = W'(3);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("pre-reset flag_compute", f_comp, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midreset flag_init", f_init, 1);
      check("midreset out_valid", out_valid, 0);
      check("midreset gcd", gcd, 0);
`ifdef GCD_ITER_COUNT_EN
      check("midreset iter", iter, 0);
`endif
      run_job("after_reset9_6", 9, 6, 3, 3, -1, 0);

      for (int k = 0; k < 40; k++) begin
         int a;
         int b;
         a = int'($urandom_range(0, 255));
         b = int'($urandom_range(0, 255));
         if (k % 10 == 0) b = a;
         run_job($sformatf("rnd%0d_%0d_%0d", k, a, b), a, b, ref_gcd(a, b), ref_cycles(a, b),
                 (k % 7 == 3 && ref_cycles(a, b) > 2) ? 1 : -1, k % 3);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
